// File: rtl/fifo_burst_reader.sv
// Burst reader for a word-counting first-word-fall-through FIFO: pops BURST_LEN words per burst
// onto a registered valid/ready stream. Define FLUSH_TIMEOUT_EN to flush partial bursts after an idle timeout.
module fifo_burst_reader #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int BURST_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DATA_WIDTH-1:0]  fifo_r_data,
  input  logic                   fifo_empty,
  input  logic [ADDRESS_WIDTH:0] fifo_word_count,
  output logic                   fifo_read,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic                   busy,
  output logic [15:0]            bursts_sent
);

  localparam int CW = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] BURST_CNT = CW'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;

  state_e                 state_q;
  logic [CW-1:0]          remaining_q;
  logic [DATA_WIDTH-1:0]  m_data_q;
  logic                   m_valid_q;
  logic                   m_last_q;
  logic [15:0]            bursts_q;

  logic pop_d;
  logic handshake_d;
  logic last_done_d;
  logic full_ok_d;

  // A pop may only refill the output register when it is empty or being drained this cycle
  assign pop_d       = (state_q == LOAD) && (remaining_q != '0) && !fifo_empty &&
                       (!m_valid_q || m_ready);
  assign handshake_d = m_valid_q && m_ready;
  assign last_done_d = handshake_d && m_last_q;
  assign full_ok_d   = enable && (fifo_word_count >= BURST_CNT);

`ifdef FLUSH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q;
  logic          timer_run_d;
  logic          timeout_d;

  assign timer_run_d = enable && !fifo_empty && (fifo_word_count < BURST_CNT);
  assign timeout_d   = timer_run_d && (timer_q == TIMER_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else if ((state_q == IDLE) && timer_run_d && !timeout_d) begin
      timer_q <= timer_q + 1'b1;
    end else begin
      timer_q <= '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      bursts_q    <= '0;
    end else begin
      if (pop_d) begin
        m_data_q    <= fifo_r_data;
        m_valid_q   <= 1'b1;
        m_last_q    <= (remaining_q == CW'(1));
        remaining_q <= remaining_q - 1'b1;
      end else if (handshake_d) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (full_ok_d) begin
            remaining_q <= BURST_CNT;
            state_q     <= LOAD;
          end
`ifdef FLUSH_TIMEOUT_EN
          else if (timeout_d) begin
            remaining_q <= fifo_word_count;
            state_q     <= LOAD;
          end
`endif
        end
        LOAD: begin
          // The final word may already be accepted on the cycle its pop count hits zero
          if (remaining_q == '0) begin
            if (last_done_d) begin
              bursts_q <= bursts_q + 16'd1;
              state_q  <= IDLE;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_done_d) begin
            bursts_q <= bursts_q + 16'd1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_read   = pop_d;
  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign busy        = (state_q != IDLE);
  assign bursts_sent = bursts_q;

endmodule
